// File: rtl/button_event_decoder_if.sv
// Bus between the keypad scanner and the button event decoder: encoded button input plus decoded events.
// "release" is a reserved word, so the release pulse vector is named release_pulse.
interface button_event_decoder_if #(
  parameter int NUM_BUTTONS = 16
);
  localparam int IDX_W = $clog2(NUM_BUTTONS);

  logic                   button_valid;
  logic [IDX_W-1:0]       button_num;
  logic [NUM_BUTTONS-1:0] buttons;
  logic [NUM_BUTTONS-1:0] press;
  logic [NUM_BUTTONS-1:0] release_pulse;
  logic                   busy;

  modport master (
    output button_valid, button_num,
    input  buttons, press, release_pulse, busy
  );

  modport slave (
    input  button_valid, button_num,
    output buttons, press, release_pulse, busy
  );
endinterface

// File: rtl/button_event_decoder.sv
// Debounces an encoded keypad index into a one-hot held vector with one-cycle press/release pulses.
// Optional auto-repeat of the press pulse while held is enabled by defining AUTO_REPEAT_EN.
module button_event_decoder #(
  parameter int NUM_BUTTONS     = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000
) (
  input logic                   clk,
  input logic                   reset,
  button_event_decoder_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_BUTTONS);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W+1)'(NUM_BUTTONS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  // An illegal parameter set never decodes any button.
  localparam bit PARAMS_OK = (NUM_BUTTONS >= 2) && (NUM_BUTTONS <= 256) &&
                             (DEBOUNCE_CYCLES >= 1) && (REPEAT_DELAY >= 1) &&
                             (REPEAT_PERIOD >= 1);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_t;

  state_t           state;
  logic [IDX_W-1:0] cap;
  logic [CNT_W-1:0] cnt;
  logic             in_range;
  logic             hit_cap;

  function automatic logic [NUM_BUTTONS-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(NUM_BUTTONS-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign in_range = PARAMS_OK && bus.button_valid && ({1'b0, bus.button_num} < NUM_EXT);
  assign hit_cap  = in_range && (bus.button_num == cap);

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_ONE         = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_first;
  logic [RPT_W-1:0] rpt_last;

  // The first repeat waits the long delay, later ones the short period.
  assign rpt_last = rpt_first ? RPT_PERIOD_LAST : RPT_DELAY_LAST;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      cap               <= '0;
      cnt               <= '0;
      bus.buttons       <= '0;
      bus.press         <= '0;
      bus.release_pulse <= '0;
      bus.busy          <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_cnt           <= '0;
      rpt_first         <= 1'b0;
`endif
    end else begin
      bus.press         <= '0;
      bus.release_pulse <= '0;
      case (state)
        IDLE: begin
          if (in_range) begin
            cap      <= bus.button_num;
            bus.busy <= 1'b1;
            if (DEBOUNCE_CYCLES == 1) begin
              state       <= HELD;
              cnt         <= CNT_MAX;
              bus.buttons <= onehot(bus.button_num);
              bus.press   <= onehot(bus.button_num);
`ifdef AUTO_REPEAT_EN
              rpt_cnt     <= '0;
              rpt_first   <= 1'b0;
`endif
            end else begin
              state <= DEB_PRESS;
              cnt   <= CNT_ONE;
            end
          end
        end

        DEB_PRESS: begin
          if (!in_range) begin
            state    <= IDLE;
            cnt      <= '0;
            bus.busy <= 1'b0;
          end else if (!hit_cap) begin
            cap <= bus.button_num;
            cnt <= CNT_ONE;
          end else if (cnt >= CNT_LAST) begin
            state       <= HELD;
            cnt         <= CNT_MAX;
            bus.buttons <= onehot(cap);
            bus.press   <= onehot(cap);
`ifdef AUTO_REPEAT_EN
            rpt_cnt     <= '0;
            rpt_first   <= 1'b0;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        HELD: begin
          if (!hit_cap) begin
            state <= DEB_RELEASE;
            cnt   <= CNT_ONE;
          end
`ifdef AUTO_REPEAT_EN
          else if (rpt_cnt == rpt_last) begin
            bus.press <= onehot(cap);
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
          end else begin
            rpt_cnt <= rpt_cnt + RPT_ONE;
          end
`endif
        end

        DEB_RELEASE: begin
          // A different index only counts as "not cap"; it is picked up again from IDLE.
          if (hit_cap) begin
            state <= HELD;
          end else if (cnt >= CNT_LAST) begin
            state             <= IDLE;
            cnt               <= '0;
            bus.buttons       <= '0;
            bus.release_pulse <= onehot(cap);
            bus.busy          <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rpt_cnt           <= '0;
            rpt_first         <= 1'b0;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
Parametrised successor to the combinational button-number-to-one-hot decoder.
- Takes an encoded button index plus valid from the front-panel keypad scanner.
- Debounces it and maintains a one-hot "held" vector.
- Emits one-cycle press/release pulses per button for the control FSMs.
- Sits between the keypad scanner and the parameter-edit logic.

Parameters:
NUM_BUTTONS, 16, number of buttons; legal range 2..256; IDX_W = $clog2(NUM_BUTTONS) is derived.
DEBOUNCE_CYCLES, 1000, consecutive identical samples needed to accept a press or a release; must be >= 1.
REPEAT_DELAY, 500000, cycles from press pulse to first auto-repeat pulse; used only with AUTO_REPEAT_EN; must be >= 1.
REPEAT_PERIOD, 100000, cycles between subsequent auto-repeat pulses; used only with AUTO_REPEAT_EN; must be >= 1.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
button_valid  input  1  a button is currently reported pressed.
button_num  input  IDX_W  index of the pressed button; ignored when button_valid=0.
buttons  output  NUM_BUTTONS  debounced held state, one-hot or all-zero.
press  output  NUM_BUTTONS  one-cycle pulse on the accepted button's bit at press, or at auto-repeat.
release  output  NUM_BUTTONS  one-cycle pulse on the released button's bit.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: asynchronous. All outputs go to 0, state goes to IDLE, counters and captured index are cleared. Takes effect immediately, including mid-debounce or mid-hold; no release pulse is generated for a button held at reset.
- Sample definition: sample = "none" if button_valid=0 or button_num >= NUM_BUTTONS; otherwise sample = button_num. Out-of-range indices are never decoded.
- cnt counts consecutive matching samples and saturates at DEBOUNCE_CYCLES. cap is the captured index.
- States: IDLE, DEB_PRESS, HELD, DEB_RELEASE.
- IDLE:
  - sample = k: cap <= k.
  - If DEBOUNCE_CYCLES = 1: go directly to HELD, with buttons[k] and press[k] set on this same edge.
  - Otherwise: cnt <= 1, go to DEB_PRESS.
- DEB_PRESS:
  - sample = cap: cnt increments. On the edge where cnt reaches DEBOUNCE_CYCLES: go to HELD, buttons <= one-hot(cap), press[cap] <= 1 for one cycle.
  - Other valid index j: cap <= j, cnt <= 1 (restart).
  - "none": go to IDLE. No pulses.
- Press latency: press and buttons become visible immediately after the DEBOUNCE_CYCLES-th consecutive matching sampling edge.
- HELD:
  - sample = cap: stay.
  - Anything else ("none" or a different index): cnt <= 1, go to DEB_RELEASE. buttons stays set.
- DEB_RELEASE:
  - sample = cap: return to HELD. No pulses.
  - Otherwise cnt increments. On reaching DEBOUNCE_CYCLES: release[cap] pulses for one cycle, buttons <= 0, go to IDLE.
  - A different index is counted as "not cap". That new button is only picked up from IDLE, starting on the next edge; presses never overlap.
- Pulses: press and release are registered and last exactly one cycle. They are never both high in the same cycle. At most one bit is set in each.
- busy = (state != IDLE), registered.

Optional Feature:
AUTO_REPEAT_EN
- Defined:
  - A repeat counter clears on the press pulse and counts in HELD.
  - A further press[cap] pulse is emitted REPEAT_DELAY cycles after the initial press pulse, then every REPEAT_PERIOD cycles while in HELD.
  - In DEB_RELEASE the counter freezes. It resumes on return to HELD. It clears on release or reset.
- Undefined: exactly one press pulse per accepted press. REPEAT_* parameters are ignored and no repeat counter is synthesised.

Test Plan:
(All with DEBOUNCE_CYCLES=4 unless stated.)
1. Clean press: valid=1, num=5 held for 6 cycles -> press=0x0020 for exactly one cycle after the 4th sampling edge; buttons=0x0020 from then on; busy=1.
2. Bounce: num=3 for 2 cycles, valid=0 for 1 cycle, num=3 for 4 cycles -> no pulse during the first burst; single press=0x0008 after the final 4th edge.
3. Release glitch: from held 5, valid=0 for 3 cycles, then num=5 again -> no release, buttons stays 0x0020. Then valid=0 for 4 cycles -> release=0x0020 one cycle, buttons=0, busy=0 next.
4. Range check and direct switch: NUM_BUTTONS=10, num=12 valid for 10 cycles -> no activity, busy=0. Held 2, then switch to num=7 -> release[2] after 4 edges, then press[7] after 4 further IDLE/DEB_PRESS edges.
5. Reset mid-operation: assert reset asynchronously while button 9 is held -> buttons, press, release and busy go to 0 immediately; no release pulse after reset deasserts.
6. AUTO_REPEAT_EN with REPEAT_DELAY=8, REPEAT_PERIOD=3, num=1 held -> press[1] at t, t+8, t+11, t+14 while held. Without the macro -> press[1] at t only.
